// File: rtl/polar_encoder_pkg.sv
// polar_encoder_pkg: default code parameters and FSM encoding shared by the encoder files.
// Rev 1.0
`default_nettype none

package polar_encoder_pkg;

  localparam int          c_N         = 8;
  localparam int          c_LOG2N     = 3;
  localparam int          c_K         = 4;
  localparam logic [7:0]  c_INFO_MASK = 8'b1110_1000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_ENC  = 2'd1,
    ST_OUT  = 2'd2
  } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/polar_encoder_stage.sv
// polar_encoder_stage: one combinational XOR-butterfly stage of x = u * F^(xLOG2N).
// Rev 1.0
`default_nettype none

module polar_encoder_stage
  import polar_encoder_pkg::*;
#(
  parameter int N     = c_N,
  parameter int LOG2N = c_LOG2N,
  parameter int SW    = 2
) (
  input  logic [N-1:0]  i_vec,
  input  logic [SW-1:0] i_stg,
  output logic [N-1:0]  o_vec
);

  logic [LOG2N-1:0] w_sel;

  for (genvar gs = 0; gs < LOG2N; gs++) begin : g_sel
    assign w_sel[gs] = (i_stg == SW'(gs));
  end

  // Lower element of each pair absorbs its partner 2^s above; upper element passes through.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [LOG2N-1:0] w_hit;
    for (genvar gs = 0; gs < LOG2N; gs++) begin : g_stg
      if (((gi >> gs) & 1) == 0) begin : g_lo
        assign w_hit[gs] = w_sel[gs] & i_vec[gi + (1 << gs)];
      end else begin : g_hi
        assign w_hit[gs] = 1'b0;
      end
    end
    assign o_vec[gi] = i_vec[gi] ^ (|w_hit);
  end

endmodule

`default_nettype wire

// File: rtl/polar_encoder.sv
// polar_encoder: serial info-bit collection, frozen-bit scatter, LOG2N butterfly stages, valid/ready output.
// Rev 1.0
`default_nettype none

module polar_encoder
  import polar_encoder_pkg::*;
#(
  parameter int             N         = c_N,
  parameter int             LOG2N     = c_LOG2N,
  parameter int             K         = c_K,
  parameter logic [N-1:0]   INFO_MASK = c_INFO_MASK
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_code,
  output logic         busy
);

  localparam int CW = $clog2(K + 1);
  localparam int SW = $clog2(LOG2N + 1);

  enc_state_t   r_state;
  enc_state_t   w_state_next;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stg;
  logic [K-1:0]  r_info;
  logic [N-1:0]  r_work;
  logic [N-1:0]  r_out_code;
  logic          r_out_valid;

  logic [K-1:0]  w_info_next;
  logic [N-1:0]  w_stage_vec;
  logic          w_accept;
  logic          w_last_accept;
  logic          w_last_stage;
  logic          w_handshake;

  // d[m] lands on the m-th set bit of INFO_MASK, counting up from bit 0.
  function automatic logic [N-1:0] scatter(input logic [K-1:0] d);
    logic [N-1:0] u;
    int           m;
    u = '0;
    m = 0;
    for (int i = 0; i < N; i++) begin
      if (INFO_MASK[i]) begin
        if (m < K) u[i] = d[m];
        m++;
      end
    end
    return u;
  endfunction

  assign w_accept      = in_valid && (r_state == ST_LOAD);
  assign w_last_accept = w_accept && (r_cnt == CW'(K - 1));
  assign w_last_stage  = (r_stg == SW'(LOG2N - 1));
  assign w_handshake   = r_out_valid && out_ready;

  always_comb begin
    w_info_next = r_info;
    for (int m = 0; m < K; m++) begin
      if (r_cnt == CW'(m)) w_info_next[m] = in_bit;
    end
  end

  polar_encoder_stage #(
    .N     (N),
    .LOG2N (LOG2N),
    .SW    (SW)
  ) u_stage (
    .i_vec (r_work),
    .i_stg (r_stg),
    .o_vec (w_stage_vec)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: if (w_last_accept) w_state_next = ST_ENC;
      ST_ENC:  if (w_last_stage)  w_state_next = ST_OUT;
      ST_OUT:  if (w_handshake)   w_state_next = ST_LOAD;
      default:                    w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The first OUT cycle registers the codeword; the handshake is taken from the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_stg       <= '0;
      r_info      <= '0;
      r_work      <= '0;
      r_out_code  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            r_info <= w_info_next;
            if (w_last_accept) begin
              r_cnt  <= '0;
              r_work <= scatter(w_info_next);
            end else begin
              r_cnt  <= r_cnt + CW'(1);
            end
          end
        end
        ST_ENC: begin
          r_work <= w_stage_vec;
          r_stg  <= w_last_stage ? '0 : r_stg + SW'(1);
        end
        ST_OUT: begin
          if (!r_out_valid) begin
            r_out_code  <= r_work;
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_cnt <= '0;
          r_stg <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_LOAD);
  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;

endmodule

`default_nettype wire

// File: tb/tb_polar_encoder.sv
// tb_polar_encoder: directed and randomised checks of polar_encoder (N=8, K=4, INFO_MASK=8'hE8).
// Rev 1.0
`default_nettype none

module tb_polar_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  polar_encoder #(
    .N         (8),
    .LOG2N     (3),
    .K         (4),
    .INFO_MASK (8'hE8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .busy      (busy)
  );

  // Independent model: x_j = XOR of u_i over all i whose bits cover j.
  function automatic logic [7:0] model(input logic [3:0] d);
    logic [7:0] u;
    logic [7:0] x;
    u = 8'h00;
    u[3] = d[0];
    u[5] = d[1];
    u[6] = d[2];
    u[7] = d[3];
    x = 8'h00;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if ((i & j) == j) x[j] = x[j] ^ u[i];
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input string tag);
    int t;
    in_valid = 1'b1;
    in_bit   = b;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL %s: in_ready timeout, got %b want 1", tag, in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] d, input int gap, input string tag);
    for (int m = 0; m < 4; m++) begin
      send_bit(d[m], tag);
      repeat (gap) step();
    end
  endtask

  task automatic recv(input logic [7:0] exp_code, input string tag);
    int t;
    out_ready = 1'b1;
    t = 0;
    while (!out_valid && t < 100) begin
      step();
      t++;
    end
    n_cmp++;
    if (!out_valid || out_code !== exp_code) begin
      n_err++;
      $display("FAIL %s: out_valid=%b out_code=%h, want valid=1 code=%h", tag, out_valid, out_code, exp_code);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_code !== 8'h00) begin n_err++; $display("FAIL reset_out_code: got %h want 00", out_code); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_bit();
    send_frame(4'b0001, 0, "single_u3");
    recv(8'h0F, "single_u3");
    send_frame(4'b1000, 0, "single_u7");
    recv(8'hFF, "single_u7");
  endtask

  task automatic test_all_ones_latency();
    int lat;
    send_frame(4'b1111, 0, "all_ones");
    n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL enc_busy: got %b want 1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL enc_in_ready: got %b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    n_cmp++; if (lat != 4)          begin n_err++; $display("FAIL latency: got %0d edges want 4", lat); end
    n_cmp++; if (out_code !== 8'h96) begin n_err++; $display("FAIL all_ones_code: got %h want 96", out_code); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_bit   = 1'b1;
      n_cmp++;
      if (out_code !== 8'h96 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure cycle %0d: code=%h valid=%b in_ready=%b want 96/1/0", c, out_code, out_valid, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    recv(8'h96, "backpressure_release");
    send_frame(4'b0001, 0, "after_backpressure");
    recv(8'h0F, "after_backpressure");
  endtask

  task automatic test_gaps();
    send_frame(4'b0110, 3, "gaps");
    recv(8'h66, "gaps");
    send_frame(4'b0110, 0, "no_gaps");
    recv(8'h66, "no_gaps");
    send_frame(4'b0101, 1, "gaps_0101");
    recv(8'h5A, "gaps_0101");
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b1, "mid_reset_pre");
    send_bit(1'b1, "mid_reset_pre");
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_state: in_ready=%b busy=%b out_valid=%b want 1/0/0", in_ready, busy, out_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    send_frame(4'b1000, 0, "mid_reset_fresh");
    recv(8'hFF, "mid_reset_fresh");
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [7:0] exp_code;
    int         t;
    logic       done;
    for (int f = 0; f < 300; f++) begin
      d = 4'($urandom);
      exp_code = model(d);
      out_ready = 1'($urandom);
      for (int m = 0; m < 4; m++) begin
        send_bit(d[m], "random_in");
        repeat ($urandom_range(0, 2)) step();
      end
      t = 0;
      done = 1'b0;
      while (!done && t < 200) begin
        out_ready = 1'($urandom);
        if (out_valid && out_ready) begin
          n_cmp++;
          if (out_code !== exp_code) begin
            n_err++;
            $display("FAIL random frame %0d d=%b: got %h want %h", f, d, out_code, exp_code);
          end
          done = 1'b1;
        end
        step();
        t++;
      end
      out_ready = 1'b0;
      if (!done) begin
        n_cmp++;
        n_err++;
        $display("FAIL random frame %0d: no output handshake, got none want %h", f, exp_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_all_ones_latency();
    test_backpressure();
    test_gaps();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
